// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
package display_pkg;

    localparam int unsigned NUM_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GAP
    } state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 found
);

    localparam int unsigned IW = $clog2(N);

    logic [IW:0]   sum;
    logic [IW-1:0] pos;

    // Scan N positions starting at ptr; the first set request wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        pos       = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IW + 1)'(k);
            if (sum >= (IW + 1)'(N)) begin
                sum = sum - (IW + 1)'(N);
            end
            pos = sum[IW-1:0];
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant_idx  = pos;
                grant[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_scheduler.sv
// Time-shares the seven-segment display among N_REQ requesters: background while idle,
// round-robin slots of HOLD_CYCLES enabled cycles, each followed by a GAP_CYCLES blank gap.
module display_scheduler
    import display_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned GAP_CYCLES  = 5_000_000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [NUM_W-1:0]         bg_number,
    input  logic [N_REQ-1:0]         req,
    input  logic [NUM_W*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]         ack,
    output logic [NUM_W-1:0]         number,
    output logic                     on,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] owner
);

    localparam int unsigned IW    = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(max_u(HOLD_CYCLES, GAP_CYCLES) + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [NUM_W-1:0]   number_q, number_d;
    logic               on_q, on_d;
    logic [N_REQ-1:0]   ack_q, ack_d;

    logic [N_REQ-1:0]   grant;
    logic [IW-1:0]      grant_idx;
    logic               found;
    logic [NUM_W-1:0]   sel_data;
    logic [IW-1:0]      next_ptr;

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .req       (req),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .found     (found)
    );

    // Select the granted requester's value using the one-hot grant.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_data = req_data[i*NUM_W +: NUM_W];
            end
        end
    end

    // Pointer advances past the owner once its slot ends, wrapping at N_REQ.
    assign next_ptr = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

    // Next-state and registered-output logic for the slot FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        number_d = number_q;
        on_d     = on_q;
        ack_d    = '0;
        unique case (state_q)
            IDLE: begin
                number_d = bg_number;
                on_d     = enable;
                if (enable && found) begin
                    owner_d  = grant_idx;
                    number_d = sel_data;
                    on_d     = 1'b1;
                    cnt_d    = CNT_W'(HOLD_CYCLES - 1);
                    state_d  = SHOW;
                end
            end
            SHOW: begin
                if (!req[owner_q]) begin
                    // Withdrawn: end early without ack, still insert a full gap.
                    ptr_d   = next_ptr;
                    cnt_d   = CNT_W'(GAP_CYCLES - 1);
                    on_d    = 1'b0;
                    state_d = GAP;
                end else if (!enable) begin
                    // Blank and freeze the slot until enable returns.
                    on_d = 1'b0;
                end else if (cnt_q == '0) begin
                    ack_d[owner_q] = 1'b1;
                    ptr_d          = next_ptr;
                    cnt_d          = CNT_W'(GAP_CYCLES - 1);
                    on_d           = 1'b0;
                    state_d        = GAP;
                end else begin
                    on_d  = 1'b1;
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                on_d = 1'b0;
                if (cnt_q == '0) begin
                    // Load background on exit so IDLE always shows it for at least a cycle.
                    number_d = bg_number;
                    on_d     = enable;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ptr_q    <= '0;
            owner_q  <= '0;
            number_q <= '0;
            on_q     <= 1'b0;
            ack_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            number_q <= number_d;
            on_q     <= on_d;
            ack_q    <= ack_d;
        end
    end

    assign ack    = ack_q;
    assign number = number_q;
    assign on     = on_q;
    assign owner  = owner_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler: directed scenarios plus random traffic against a slot-level model.
module tb_display_scheduler;

    localparam int N = 4;
    localparam int H = 8;
    localparam int G = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] bg_number;
    logic [3:0]  req;
    logic [63:0] req_data;
    logic [3:0]  ack;
    logic [15:0] number;
    logic        on;
    logic        busy;
    logic [1:0]  owner;

    int total = 0;
    int bad   = 0;

    display_scheduler #(
        .N_REQ       (N),
        .HOLD_CYCLES (H),
        .GAP_CYCLES  (G)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .bg_number (bg_number),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .number    (number),
        .on        (on),
        .busy      (busy),
        .owner     (owner)
    );

    always #5 clk = ~clk;

    // Slot-level model: phase (0 background, 1 showing, 2 gap) and cycles left in that phase.
    int          m_phase = 0;
    int          m_left  = 0;
    int          m_next  = 0;
    logic [15:0] e_number = '0;
    logic        e_on     = 1'b0;
    logic [3:0]  e_ack    = '0;
    logic [1:0]  e_owner  = '0;

    task automatic end_slot(input logic acked);
        e_ack        = '0;
        if (acked) e_ack[e_owner] = 1'b1;
        m_next       = (int'(e_owner) + 1) % N;
        m_phase      = 2;
        m_left       = G;
        e_on         = 1'b0;
    endtask

    task automatic model_step();
        int pick;
        e_ack = '0;
        if (!rst_n) begin
            m_phase = 0; m_left = 0; m_next = 0;
            e_number = '0; e_on = 1'b0; e_owner = '0;
            return;
        end
        case (m_phase)
            0: begin
                e_number = bg_number;
                e_on     = enable;
                pick     = -1;
                for (int k = 0; k < N; k++) begin
                    if (pick < 0 && req[(m_next + k) % N]) pick = (m_next + k) % N;
                end
                if (enable && pick >= 0) begin
                    e_owner  = 2'(pick);
                    e_number = req_data[pick*16 +: 16];
                    e_on     = 1'b1;
                    m_phase  = 1;
                    m_left   = H;
                end
            end
            1: begin
                if (!req[e_owner]) end_slot(1'b0);
                else if (!enable) e_on = 1'b0;
                else begin
                    m_left--;
                    if (m_left == 0) end_slot(1'b1);
                    else e_on = 1'b1;
                end
            end
            default: begin
                e_on = 1'b0;
                m_left--;
                if (m_left == 0) begin
                    m_phase  = 0;
                    e_number = bg_number;
                    e_on     = enable;
                end
            end
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model advances on every rising edge from the same inputs the DUT samples.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Compare every cycle, away from the active edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("number", 32'(number), 32'(e_number));
            check("on",     32'(on),     32'(e_on));
            check("ack",    32'(ack),    32'(e_ack));
            check("busy",   32'(busy),   32'(m_phase != 0));
            check("owner",  32'(owner),  32'(e_owner));
        end
    end

    int grant_order[$];
    int ack_cnt[N];

    // Run until all requests are served; each requester drops its request on its ack.
    task automatic serve();
        int   guard;
        logic prev_busy;
        grant_order.delete();
        for (int i = 0; i < N; i++) ack_cnt[i] = 0;
        guard     = 0;
        prev_busy = busy;
        while ((req != 4'b0 || busy) && guard < 200) begin
            @(negedge clk);
            guard++;
            if (busy && !prev_busy) grant_order.push_back(int'(owner));
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    ack_cnt[i]++;
                    req[i] = 1'b0;
                end
            end
            prev_busy = busy;
        end
        check("serve_bound", 32'(guard < 200), 32'd1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int on_cnt;
        int guard;
        rst_n = 1'b0; enable = 1'b0; bg_number = '0; req = '0; req_data = '0;

        // Reset / idle
        step(3);
        check("rst_number", 32'(number), 32'd0);
        check("rst_on",     32'(on),     32'd0);
        check("rst_ack",    32'(ack),    32'd0);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_owner",  32'(owner),  32'd0);
        rst_n = 1'b1; enable = 1'b1; bg_number = 16'h1234;
        step(1);
        check("idle_on",     32'(on),     32'd1);
        check("idle_number", 32'(number), 32'h1234);
        check("idle_busy",   32'(busy),   32'd0);

        // Single request
        req_data[2*16 +: 16] = 16'hBEEF;
        req = 4'b0100;
        step(1);
        check("single_number", 32'(number),  32'hBEEF);
        check("single_owner",  32'(owner),   32'd2);
        check("model_owner",   32'(e_owner), 32'd2);
        check("model_number",  32'(e_number), 32'hBEEF);
        on_cnt = int'(on);
        for (int c = 0; c < 7; c++) begin
            step(1);
            on_cnt += int'(on);
            check("single_noack", 32'(ack), 32'd0);
        end
        check("single_on_cycles", 32'(on_cnt), 32'd8);
        step(1);
        check("single_ack",   32'(ack), 32'b0100);
        check("single_gap0",  32'(on),  32'd0);
        req = 4'b0;
        step(1);
        check("single_gap1",  32'(on),  32'd0);
        check("single_ack_1cyc", 32'(ack), 32'd0);
        step(1);
        check("single_bg_on",     32'(on),     32'd1);
        check("single_bg_number", 32'(number), 32'h1234);
        check("single_bg_busy",   32'(busy),   32'd0);

        // Round-robin from a fresh pointer
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1);
        req_data = 64'hA003_A002_A001_A000;
        req = 4'b1011;
        serve();
        check("rr_count", 32'(grant_order.size()), 32'd3);
        if (grant_order.size() == 3) begin
            check("rr_first",  32'(grant_order[0]), 32'd0);
            check("rr_second", 32'(grant_order[1]), 32'd1);
            check("rr_third",  32'(grant_order[2]), 32'd3);
        end
        check("rr_ack0", 32'(ack_cnt[0]), 32'd1);
        check("rr_ack1", 32'(ack_cnt[1]), 32'd1);
        check("rr_ack2", 32'(ack_cnt[2]), 32'd0);
        check("rr_ack3", 32'(ack_cnt[3]), 32'd1);

        // Wrap after owner 3
        req = 4'b1001;
        step(1);
        check("wrap_owner",  32'(owner),  32'd0);
        check("wrap_number", 32'(number), 32'hA000);
        serve();
        check("wrap_next", 32'(grant_order.size() == 1 && grant_order[0] == 3), 32'd1);

        // Withdrawal in the 4th SHOW cycle
        req = 4'b0010;
        step(1);
        check("wd_owner", 32'(owner), 32'd1);
        step(3);
        req = 4'b0;
        step(1);
        check("wd_gap0_on",  32'(on),   32'd0);
        check("wd_gap0_ack", 32'(ack),  32'd0);
        check("wd_gap0_busy", 32'(busy), 32'd1);
        step(1);
        check("wd_gap1_on",  32'(on),   32'd0);
        check("wd_gap1_ack", 32'(ack),  32'd0);
        step(1);
        check("wd_idle", 32'(busy), 32'd0);
        req = 4'b0101;
        step(1);
        check("wd_next_owner", 32'(owner), 32'd2);
        serve();

        // Enable freeze mid-SHOW
        req = 4'b1000;
        on_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            step(1);
            on_cnt += int'(on);
        end
        enable = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step(1);
            check("freeze_off", 32'(on), 32'd0);
            check("freeze_busy", 32'(busy), 32'd1);
        end
        enable = 1'b1;
        guard = 0;
        while (guard < 40) begin
            step(1);
            guard++;
            if (ack != 4'b0) break;
            on_cnt += int'(on);
        end
        check("freeze_ack", 32'(ack), 32'b1000);
        check("freeze_on_cycles", 32'(on_cnt), 32'd8);
        req = 4'b0;
        step(3);

        // Reset abort mid-SHOW
        req = 4'b0001;
        step(1);
        check("abort_busy", 32'(busy), 32'd1);
        step(2);
        rst_n = 1'b0;
        step(1);
        check("abort_number", 32'(number), 32'd0);
        check("abort_on",     32'(on),     32'd0);
        check("abort_ack",    32'(ack),    32'd0);
        check("abort_busy0",  32'(busy),   32'd0);
        check("abort_owner",  32'(owner),  32'd0);
        rst_n = 1'b1;
        req = 4'b0;
        for (int c = 0; c < 12; c++) begin
            step(1);
            check("abort_noack", 32'(ack), 32'd0);
        end

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst_n  = ($urandom_range(0, 199) != 0);
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 31) == 0) bg_number = 16'($urandom);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 15) == 0) begin
                    req[i] = ~req[i];
                    if (req[i]) req_data[i*16 +: 16] = 16'($urandom);
                end
                if (ack[i] && $urandom_range(0, 1) == 0) req[i] = 1'b0;
            end
        end
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_scheduler.md
# display_scheduler

Time-shares the board's 4-digit seven-segment display among `N_REQ` requesters. It drives the `number` and `on` inputs of the seven-segment multiplexer. When no requester is pending, it shows a background value. Otherwise it grants the display to one requester for a fixed hold time, picked round-robin. Each grant is followed by a short blank gap so the change is visible, and each completed slot is acknowledged with a one-cycle pulse.

## Interface
- `N_REQ`, 4: number of requesters; 2..8.
- `HOLD_CYCLES`, 50_000_000: cycles one granted value stays on screen; ≥1.
- `GAP_CYCLES`, 5_000_000: blank cycles after each slot; ≥1.
- `clk`  in  1  system clock; the single clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `enable`  in  1  global display enable; low blanks the display and freezes slot timing.
- `bg_number`  in  16  background value, shown while idle.
- `req`  in  N_REQ  per-requester level request; held until `ack` or withdrawn.
- `req_data`  in  16*N_REQ  requester i's value at bits [16i+15:16i].
- `ack`  out  N_REQ  one-cycle pulse to the owner when its slot completes.
- `number`  out  16  registered value for the display multiplexer.
- `on`  out  1  registered display enable for the multiplexer.
- `busy`  out  1  high in SHOW and GAP.
- `owner`  out  $clog2(N_REQ)  index of the current or most recent grantee.

## Operation
- FSM states:
  - IDLE: background shown; grants are made only from this state.
  - SHOW: granted value on screen; hold counter runs.
  - GAP: display blanked; gap counter runs.
- IDLE, registered every cycle: `number`←`bg_number`, `on`←`enable`.
  - If `enable` and any `req` bit is set, pick the first set bit searching upward from `ptr`, wrapping modulo N_REQ.
  - On a grant: `owner`←i, `number`←req_data[i], `on`←1, cnt←HOLD_CYCLES-1, go to SHOW.
- SHOW, with `enable`=1:
  - `on`=1 and `number` is held.
  - If cnt==0: pulse ack[owner], set `ptr`←owner+1 (wraps), cnt←GAP_CYCLES-1, go to GAP.
  - Otherwise cnt←cnt-1.
- SHOW, with `enable`=0: `on`=0 and cnt is frozen. The slot resumes when `enable` returns.
- Withdrawal during SHOW: if req[owner] drops, the slot ends early.
  - No ack is issued.
  - `ptr`←owner+1 and the FSM goes to GAP with full GAP_CYCLES.
- GAP: `on`=0 and `number` is held. cnt counts down; at 0 go to IDLE. Not frozen by `enable`.
- `req` bits of non-owners are ignored outside IDLE. A requester that stays asserted after its `ack` is treated as a new request at the next IDLE.
- Counter width is $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1). It never underflows.
- `ptr` is internal; it resets to 0.

## Timing
- Reset (rst_n=0 at a clk edge) sets every output to 0: `number`, `on`, `ack`, `busy`, `owner`.
  - Also: `ptr`=0, cnt=0, state=IDLE.
  - Reset mid-SHOW or mid-GAP aborts the slot with no ack.
- IDLE grant latency: `req` seen at edge t ⇒ `number`=req_data, `on`=1, `busy`=1 from edge t+1.
- SHOW lasts exactly HOLD_CYCLES enabled cycles.
- `ack` is high for the single cycle following the last SHOW cycle, coincident with the first GAP cycle.
- GAP lasts exactly GAP_CYCLES cycles.
- At least one IDLE cycle always occurs between slots. Background appears for ≥1 cycle.
- Simultaneous requests: one grant per IDLE decision. The others wait, and are served round-robin.
- `bg_number` change is reflected in IDLE with 1-cycle latency.

## Structure
- Package `display_pkg`:
  - state enum {IDLE, SHOW, GAP};
  - `NUM_W`=16.
- Sub-module `rr_arbiter`: combinational, parameter N. Inputs: req vector, ptr. Outputs: one-hot grant and grant index, with found flag.
- The FSM, counter, ptr and output registers live in `display_scheduler`.

## Test plan
All scenarios use N_REQ=4, HOLD_CYCLES=8, GAP_CYCLES=2.
- **Reset/idle:** hold rst_n=0 for 3 cycles, then release with enable=1, bg_number=16'h1234.
  - During reset: all outputs 0.
  - One cycle after release: on=1, number=16'h1234, busy=0.
- **Single request:** req=4'b0100, req_data[2]=16'hBEEF.
  - Next cycle: number=16'hBEEF, owner=2.
  - 8 cycles on, then ack=4'b0100 for 1 cycle.
  - 2 cycles with on=0, then background returns.
- **Round-robin:** req=4'b1011 held, each requester deasserting after its ack.
  - Grant order: 0, 1, 3.
  - Exactly one ack per requester.
- **Wrap:** after owner=3 completes, assert req=4'b1001. Next grant is owner=0.
- **Withdrawal:** drop req[owner] in the 4th SHOW cycle.
  - No ack.
  - GAP of 2 cycles.
  - Next grant goes to owner+1.
- **Enable freeze:** deassert enable for 5 cycles mid-SHOW.
  - on=0 for those 5 cycles.
  - The slot still shows 8 enabled cycles in total before ack.
- **Reset abort:** pulse rst_n=0 mid-SHOW.
  - No ack is issued.
  - All outputs 0 on the next cycle.
